// File: rtl/seq_shifter.sv
// Iterative shifter/rotator: one single-bit step per clock.
// start/busy/done handshake with registered carry and zero flags.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] sout,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sout_q, sout_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] step_s;
    logic             step_c;
    logic             is_shift;

    assign is_shift = (op == OP_LSL) || (op == OP_LSR) ||
                      (op == OP_ASR) || (op == OP_ROL) ||
                      (op == OP_ROR);

    always_comb begin
        step_s = sout_q;
        step_c = 1'b0;
        case (op_q)
            OP_LSL: begin
                step_s = {sout_q[WIDTH-2:0], 1'b0};
                step_c = sout_q[WIDTH-1];
            end
            OP_LSR: begin
                step_s = {1'b0, sout_q[WIDTH-1:1]};
                step_c = sout_q[0];
            end
            OP_ASR: begin
                step_s = {sout_q[WIDTH-1], sout_q[WIDTH-1:1]};
                step_c = sout_q[0];
            end
            OP_ROL: begin
                step_s = {sout_q[WIDTH-2:0], sout_q[WIDTH-1]};
                step_c = sout_q[WIDTH-1];
            end
            OP_ROR: begin
                step_s = {sout_q[0], sout_q[WIDTH-1:1]};
                step_c = sout_q[0];
            end
            default: begin
                step_s = sout_q;
                step_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        sout_d  = sout_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sout_d  = in;
                    op_d    = op;
                    carry_d = 1'b0;
                    count_d = amt;
                    // Nothing to do: result is final at the accept edge
                    if (amt == '0 || !is_shift) begin
                        state_d = DONE;
                        zero_d  = (in == '0);
                    end else begin
                        state_d = SHIFT;
                        zero_d  = 1'b0;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sout_d  = step_s;
                carry_d = step_c;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                    zero_d  = (step_s == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sout_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sout_q  <= sout_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    assign sout  = sout_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed vector table, handshake/reset
// sequences and random ops against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  d_in;
    logic [2:0]    d_op;
    logic [3:0]    d_amt;
    logic [W-1:0]  sout;
    logic          busy, done, carry, zero;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] trace[$];

    seq_shifter #(.WIDTH(W), .AMT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in(d_in), .op(d_op), .amt(d_amt),
        .sout(sout), .busy(busy), .done(done),
        .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] din;
        logic [3:0]   amt;
        logic [W-1:0] es;
        logic         ec;
        logic         ez;
        int           eb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void ref_model(
        input  logic [2:0]   o,
        input  logic [W-1:0] d,
        input  logic [3:0]   n,
        output logic [W-1:0] r,
        output logic         c,
        output int           b
    );
        logic [31:0] w;
        logic signed [W-1:0] s;
        int k;
        int ni;
        ni = int'(n);
        r = d;
        c = 1'b0;
        b = 0;
        if (ni != 0 && o >= 3'd1 && o <= 3'd5) begin
            b = ni;
            k = ni % W;
            case (o)
                3'd1: begin
                    w = {16'h0, d} << ni;
                    r = w[W-1:0];
                    c = w[W];
                end
                3'd2: begin
                    r = d >> ni;
                    w = {16'h0, d} >> (ni - 1);
                    c = w[0];
                end
                3'd3: begin
                    s = d;
                    r = s >>> ni;
                    s = s >>> (ni - 1);
                    c = s[0];
                end
                3'd4: begin
                    r = (d << k) | (d >> (W - k));
                    c = r[0];
                end
                default: begin
                    r = (d >> k) | (d << (W - k));
                    c = r[W-1];
                end
            endcase
        end
    endfunction

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            trace.push_back(sout);
        end
    endtask

    task automatic run_op(
        input string        tag,
        input logic [2:0]   o,
        input logic [W-1:0] d,
        input logic [3:0]   n,
        input logic [W-1:0] es,
        input logic         ec,
        input logic         ez,
        input int           eb
    );
        int  nb;
        bit  ok;
        trace.delete();
        @(negedge clk);
        start = 1'b1;
        d_in  = d;
        d_op  = o;
        d_amt = n;
        @(negedge clk);
        start = 1'b0;
        d_in  = W'($urandom);
        d_op  = 3'($urandom);
        d_amt = 4'($urandom);
        trace.push_back(sout);
        chk({tag, " accept_sout"}, 32'(sout), 32'(d));
        nb = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
            trace.push_back(sout);
        end
        chk({tag, " done_seen"}, 32'(ok), 32'd1);
        chk({tag, " sout"}, 32'(sout), 32'(es));
        chk({tag, " carry"}, 32'(carry), 32'(ec));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
        chk({tag, " busy_cycles"}, 32'(nb), 32'(eb));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[12];
    logic [W-1:0] r;
    logic c;
    int b;
    bit ok;
    int ndone;

    initial begin
        vecs[0]  = '{3'b001, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b0, 1};
        vecs[1]  = '{3'b011, 16'h8000, 4'd4,  16'hF800, 1'b0, 1'b0, 4};
        vecs[2]  = '{3'b100, 16'h8001, 4'd4,  16'h0018, 1'b0, 1'b0, 4};
        vecs[3]  = '{3'b101, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0, 1};
        vecs[4]  = '{3'b010, 16'h00FF, 4'd15, 16'h0000, 1'b0, 1'b1, 15};
        vecs[5]  = '{3'b000, 16'h1234, 4'd5,  16'h1234, 1'b0, 1'b0, 0};
        vecs[6]  = '{3'b001, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0, 0};
        vecs[7]  = '{3'b111, 16'h1234, 4'd5,  16'h1234, 1'b0, 1'b0, 0};
        vecs[8]  = '{3'b110, 16'h0000, 4'd3,  16'h0000, 1'b0, 1'b1, 0};
        vecs[9]  = '{3'b001, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0, 15};
        vecs[10] = '{3'b011, 16'h7FFF, 4'd15, 16'h0000, 1'b1, 1'b1, 15};
        vecs[11] = '{3'b100, 16'h8000, 4'd15, 16'h4000, 1'b0, 1'b0, 15};

        reset = 1'b1;
        start = 1'b0;
        d_in  = '0;
        d_op  = '0;
        d_amt = '0;
        repeat (2) @(negedge clk);
        chk("rst sout", 32'(sout), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst carry", 32'(carry), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din,
                   vecs[i].amt, vecs[i].es, vecs[i].ec,
                   vecs[i].ez, vecs[i].eb);

        run_op("asr_trace", 3'b011, 16'h8000, 4'd4,
               16'hF800, 1'b0, 1'b0, 4);
        chk("asr_trace len", 32'(trace.size()), 32'd5);
        if (trace.size() == 5) begin
            chk("asr_trace s1", 32'(trace[1]), 32'hC000);
            chk("asr_trace s2", 32'(trace[2]), 32'hE000);
            chk("asr_trace s3", 32'(trace[3]), 32'hF000);
            chk("asr_trace s4", 32'(trace[4]), 32'hF800);
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        d_in  = 16'h00FF;
        d_op  = 3'b001;
        d_amt = 4'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        d_in  = 16'hFFFF;
        d_op  = 3'b010;
        d_amt = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        chk("ign done_seen", 32'(ok), 32'd1);
        chk("ign sout", 32'(sout), 32'hFF00);
        chk("ign carry", 32'(carry), 32'd0);
        @(negedge clk);
        chk("ign no_reaccept", 32'(busy | done), 32'd0);
        chk("ign hold", 32'(sout), 32'hFF00);

        // back-to-back: start held into the DONE cycle
        @(negedge clk);
        start = 1'b1;
        d_in  = 16'h8001;
        d_op  = 3'b001;
        d_amt = 4'd1;
        @(negedge clk);
        wait_done(ok);
        chk("b2b first_done", 32'(ok), 32'd1);
        chk("b2b first_sout", 32'(sout), 32'h0002);
        d_in  = 16'h0001;
        d_op  = 3'b101;
        d_amt = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b done_low", 32'(done), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b accept", 32'(sout), 32'h0001);
        wait_done(ok);
        chk("b2b second_done", 32'(ok), 32'd1);
        chk("b2b sout", 32'(sout), 32'h8000);
        chk("b2b carry", 32'(carry), 32'd1);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1;
        d_in  = 16'hFFFF;
        d_op  = 3'b001;
        d_amt = 4'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid busy_before", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid sout", 32'(sout), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid done", 32'(done), 32'd0);
        chk("mid carry", 32'(carry), 32'd0);
        chk("mid zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mid no_done", 32'(ndone), 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] rd;
            logic [3:0]   rn;
            ro = 3'($urandom_range(7, 0));
            rd = W'($urandom);
            rn = 4'($urandom_range(15, 0));
            ref_model(ro, rd, rn, r, c, b);
            run_op($sformatf("rnd%0d op%0d in%h n%0d", i, ro, rd, rn),
                   ro, rd, rn, r, c, (r == '0), b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, iterative shifter/rotator for the datapath. It is the multi-cycle successor to the single-bit combinational shifter. It accepts a WIDTH-bit operand, an operation code and a shift amount. It performs one single-bit step per clock and reports completion through a start/busy/done handshake, with carry-out and zero status flags. It sits between the register file read port and the ALU/writeback mux, for shift-by-register instructions.

## Interface
- WIDTH, default 16: operand and result width; legal values are ≥ 2.
- AMT_W, default $clog2(WIDTH): width of the shift-amount input.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request pulse; sampled only when not busy.
- in  input  WIDTH  operand; sampled with start.
- op  input  3  operation code: 000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR; 110 and 111 are reserved and behave as pass.
- amt  input  AMT_W  number of single-bit steps; sampled with start.
- sout  output  WIDTH  result register; holds its value until the next accepted start.
- busy  output  1  high while steps remain.
- done  output  1  one-cycle pulse when sout/carry/zero become valid.
- carry  output  1  last bit shifted or rotated out; 0 if no step was performed.
- zero  output  1  high when the final sout equals 0.

## Operation
- States: IDLE, SHIFT, DONE.
- The state machine is fully encoded; any illegal encoding returns to IDLE.
- IDLE or DONE with start=1 (accept):
  - Latch in into sout, and latch op and amt.
  - Clear carry.
  - If amt==0, or op is pass/reserved, go to DONE.
  - Otherwise, load count=amt and go to SHIFT.
- IDLE with start=0: hold.
- DONE with start=0: go to IDLE.
- SHIFT: each edge performs one step on sout and decrements count. When count becomes 0, go to DONE.
- Step definitions (single bit):
  - LSL: sout={sout[W-2:0],0}, carry=sout[W-1].
  - LSR: sout={0,sout[W-1:1]}, carry=sout[0].
  - ASR: sout={sout[W-1],sout[W-1:1]}, carry=sout[0].
  - ROL: sout={sout[W-2:0],sout[W-1]}, carry=sout[W-1].
  - ROR: sout={sout[0],sout[W-1:1]}, carry=sout[0].
- amt ≥ WIDTH (possible when WIDTH is not a power of two) gets no special case; the block performs amt steps. Logical shifts therefore give 0, ASR gives full sign fill, and rotates give amt mod WIDTH.
- busy = (state==SHIFT). done = (state==DONE).
- zero is registered. It is updated on entry to DONE, equals (result==0), and holds until the next accept.
- start while busy is ignored; no queueing, and the in-flight operation is unaffected.
- Changes on in, op or amt after the accept edge have no effect.

## Timing
- Reset values: state=IDLE, sout=0, carry=0, zero=0, busy=0, done=0, count=0.
- Reset is asynchronous and takes effect mid-operation. The in-flight result is discarded and no done is produced.
- Start is accepted at edge k. sout shows in after edge k.
- For amt=n≥1, busy is high after edges k through k+n−1. sout changes after each edge k+1..k+n, and the final result is visible after edge k+n.
- done is high for exactly the one cycle after edge k+n. For n=0 or pass, done is high for the cycle after edge k.
- Back-to-back operation: start held high in the DONE cycle is accepted at that edge, so done is low for the new operation's first cycle. Throughput is n+1 cycles per operation (1 for n=0).
- Outputs are driven directly from registers; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, LSL in=0x8001 amt=1:
  - busy is high 1 cycle; done follows.
  - sout=0x0002, carry=1, zero=0.
- ASR in=0x8000 amt=4:
  - busy is high for 4 cycles.
  - Intermediate values are 0xC000, 0xE000, 0xF000, then 0xF800.
  - carry=0; done pulses once.
- Rotates:
  - ROL in=0x8001 amt=4 gives sout=0x0018, carry=0.
  - ROR in=0x0001 amt=1 gives sout=0x8000, carry=1.
- LSR in=0x00FF amt=15 gives sout=0x0000, carry=0, zero=1.
- Pass op and amt=0 with in=0x1234:
  - done appears in the cycle after accept; sout=0x1234, carry=0, busy never rises.
  - op=111 gives the same result.
- Handshake and reset:
  - Pulse start with in=0xFFFF during busy on an LSL amt=8 of 0x00FF. The result stays 0xFF00, carry=0.
  - A second start held during DONE is accepted with no IDLE gap.
  - Asserting reset at step 3 of a 10-step operation clears all outputs immediately, and no done follows.
